// File: rtl/alu_issue_if.sv
// Request/response bundle between an issue source and alu_issue, plus the
// shared ALU operation codes used on alu_ctrl_o.
`ifndef ALU_ISSUE_CODES
`define ALU_ISSUE_CODES
`define ALU_AND  3'd0
`define ALU_XOR  3'd1
`define ALU_SLL  3'd2
`define ALU_ADD  3'd3
`define ALU_SUB  3'd4
`define ALU_MUL  3'd5
`define ALU_ADDI 3'd6
`define ALU_SRAI 3'd7
`endif

interface alu_issue_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_illegal_o;

  modport slave (
    input  req_valid_i, opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i,
           imm_i, alu_result_i, rsp_ready_i,
    output req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o, rsp_valid_o,
           rsp_data_o, rsp_illegal_o
  );

  modport master (
    output req_valid_i, opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i,
           imm_i, alu_result_i, rsp_ready_i,
    input  req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o, rsp_valid_o,
           rsp_data_o, rsp_illegal_o
  );
endinterface

// File: rtl/alu_issue.sv
// Decodes one integer instruction, drives an external ALU, and returns its result.
// Define ALU_MUL_EN to decode MUL with a MUL_LAT-cycle execute phase.
module alu_issue #(
  parameter int MUL_LAT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("alu_issue: MUL_LAT must be within 1..15");
  end

  state_t      state_reg;
  logic        ready_reg;
  logic        valid_reg;
  logic        illegal_reg;
  logic [31:0] data_reg;
  logic [31:0] data1_reg;
  logic [31:0] data2_reg;
  logic [2:0]  ctrl_reg;

  logic        dec_legal;
  logic        dec_use_imm;
  logic [2:0]  dec_ctrl;
`ifdef ALU_MUL_EN
  logic        dec_mul;
  logic [3:0]  cnt_reg;
`endif

  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_ctrl    = `ALU_ADD;
`ifdef ALU_MUL_EN
    dec_mul     = 1'b0;
`endif
    case (bus.opcode_i)
      7'b0110011: begin
        if (bus.funct7_i == 7'b0000000) begin
          dec_legal = 1'b1;
          case (bus.funct3_i)
            3'b111:  dec_ctrl = `ALU_AND;
            3'b100:  dec_ctrl = `ALU_XOR;
            3'b001:  dec_ctrl = `ALU_SLL;
            3'b000:  dec_ctrl = `ALU_ADD;
            default: dec_legal = 1'b0;
          endcase
        end else if (bus.funct7_i == 7'b0100000 && bus.funct3_i == 3'b000) begin
          dec_legal = 1'b1;
          dec_ctrl  = `ALU_SUB;
        end
`ifdef ALU_MUL_EN
        else if (bus.funct7_i == 7'b0000001 && bus.funct3_i == 3'b000) begin
          dec_legal = 1'b1;
          dec_ctrl  = `ALU_MUL;
          dec_mul   = 1'b1;
        end
`endif
      end
      7'b0010011: begin
        if (bus.funct3_i == 3'b000) begin
          dec_legal   = 1'b1;
          dec_use_imm = 1'b1;
          dec_ctrl    = `ALU_ADDI;
        end else if (bus.funct3_i == 3'b101 && bus.funct7_i == 7'b0100000) begin
          dec_legal   = 1'b1;
          dec_use_imm = 1'b1;
          dec_ctrl    = `ALU_SRAI;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b1;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      data_reg    <= 32'd0;
      data1_reg   <= 32'd0;
      data2_reg   <= 32'd0;
      ctrl_reg    <= `ALU_ADD;
`ifdef ALU_MUL_EN
      cnt_reg     <= 4'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid_i) begin
            ready_reg <= 1'b0;
            if (dec_legal) begin
              state_reg <= EXEC;
              data1_reg <= bus.rs1_data_i;
              data2_reg <= dec_use_imm ? bus.imm_i : bus.rs2_data_i;
              ctrl_reg  <= dec_ctrl;
`ifdef ALU_MUL_EN
              cnt_reg   <= dec_mul ? 4'(MUL_LAT - 1) : 4'd0;
`endif
            end else begin
              // Undecodable: skip EXEC and leave the ALU operands untouched.
              state_reg   <= DONE;
              valid_reg   <= 1'b1;
              illegal_reg <= 1'b1;
              data_reg    <= 32'd0;
            end
          end
        end
        EXEC: begin
`ifdef ALU_MUL_EN
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else
`endif
          begin
            state_reg   <= DONE;
            valid_reg   <= 1'b1;
            illegal_reg <= 1'b0;
            data_reg    <= bus.alu_result_i;
          end
        end
        DONE: begin
          if (bus.rsp_ready_i) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = ready_reg;
  assign bus.rsp_valid_o   = valid_reg;
  assign bus.rsp_illegal_o = illegal_reg;
  assign bus.rsp_data_o    = data_reg;
  assign bus.alu_data1_o   = data1_reg;
  assign bus.alu_data2_o   = data2_reg;
  assign bus.alu_ctrl_o    = ctrl_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue with a behavioural ALU and
// an instruction-level reference model.
module tb_alu_issue;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] exp_d1   = 32'd0;
  logic [31:0] exp_d2   = 32'd0;
  logic [2:0]  exp_ctrl = `ALU_ADD;

  alu_issue_if bus();

  alu_issue #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment ALU: purely combinational on the issued operands.
  always_comb begin
    bus.alu_result_i = 32'd0;
    case (bus.alu_ctrl_o)
      `ALU_AND:  bus.alu_result_i = bus.alu_data1_o & bus.alu_data2_o;
      `ALU_XOR:  bus.alu_result_i = bus.alu_data1_o ^ bus.alu_data2_o;
      `ALU_SLL:  bus.alu_result_i = bus.alu_data1_o << bus.alu_data2_o[4:0];
      `ALU_ADD:  bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
      `ALU_SUB:  bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
      `ALU_MUL:  bus.alu_result_i = bus.alu_data1_o * bus.alu_data2_o;
      `ALU_ADDI: bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
      `ALU_SRAI: bus.alu_result_i = $signed(bus.alu_data1_o) >>> bus.alu_data2_o[4:0];
      default:   bus.alu_result_i = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: what the instruction means, not how it is decoded.
  function automatic void ref_model(
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] imm,
    output bit          legal,
    output logic [2:0]  ctrl,
    output logic [31:0] opnd2,
    output logic [31:0] res,
    output int          lat
  );
    bit mul_en;
`ifdef ALU_MUL_EN
    mul_en = 1'b1;
`else
    mul_en = 1'b0;
`endif
    legal = 1'b1;
    ctrl  = `ALU_ADD;
    opnd2 = b;
    res   = 32'd0;
    lat   = 1;
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin
      ctrl = `ALU_AND; res = a & b;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) begin
      ctrl = `ALU_XOR; res = a ^ b;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd1) begin
      ctrl = `ALU_SLL; res = a << (b % 32);
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin
      ctrl = `ALU_ADD; res = a + b;
    end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
      ctrl = `ALU_SUB; res = a - b;
    end else if (mul_en && op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin
      ctrl = `ALU_MUL; res = a * b; lat = MUL_LAT;
    end else if (op == 7'h13 && f3 == 3'd0) begin
      ctrl = `ALU_ADDI; opnd2 = imm; res = a + imm;
    end else if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h20) begin
      ctrl = `ALU_SRAI; opnd2 = imm;
      res = 32'($signed(a) >>> (imm % 32));
    end else begin
      legal = 1'b0; lat = 0;
    end
  endfunction

  task automatic drive_garbage();
    bus.opcode_i   = 7'($urandom);
    bus.funct3_i   = 3'($urandom);
    bus.funct7_i   = 7'($urandom);
    bus.rs1_data_i = $urandom;
    bus.rs2_data_i = $urandom;
    bus.imm_i      = $urandom;
  endtask

  task automatic check_alu_held(input string tag);
    check({tag, "_ctrl"}, 32'(bus.alu_ctrl_o), 32'(exp_ctrl));
    check({tag, "_d1"}, bus.alu_data1_o, exp_d1);
    check({tag, "_d2"}, bus.alu_data2_o, exp_d2);
  endtask

  // One request/response; hold = DONE cycles with rsp_ready low before release.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input int hold);
    bit          legal;
    logic [2:0]  ctrl;
    logic [31:0] opnd2, res;
    int          lat, exp_lat;
    ref_model(op, f3, f7, a, b, imm, legal, ctrl, opnd2, res, exp_lat);
    check("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
    bus.opcode_i = op; bus.funct3_i = f3; bus.funct7_i = f7;
    bus.rs1_data_i = a; bus.rs2_data_i = b; bus.imm_i = imm;
    bus.req_valid_i = 1'b1;
    bus.rsp_ready_i = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1;
    drive_garbage();
    if (legal) begin
      exp_d1 = a; exp_d2 = opnd2; exp_ctrl = ctrl;
    end
    check_alu_held("accept");
    check("req_ready_busy", 32'(bus.req_ready_o), 32'd0);
    lat = 0;
    while (!bus.rsp_valid_o && lat < 40) begin
      @(posedge clk); #1;
      drive_garbage();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", bus.rsp_data_o, res);
    check("rsp_illegal", 32'(bus.rsp_illegal_o), 32'(!legal));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      drive_garbage();
      check("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("hold_data", bus.rsp_data_o, res);
      check("hold_ready", 32'(bus.req_ready_o), 32'd0);
    end
    check_alu_held("done");
    // Release with a fresh request pending: it must not be taken in the same cycle.
    bus.rsp_ready_i = 1'b1;
    bus.opcode_i = 7'h33; bus.funct3_i = 3'd4; bus.funct7_i = 7'h00;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("release_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("release_ready", 32'(bus.req_ready_o), 32'd1);
    check_alu_held("release");
    $display("txn op=%02h f3=%0d f7=%02h a=%08h b=%08h imm=%08h hold=%0d -> data=%08h illegal=%0d lat=%0d",
             op, f3, f7, a, b, imm, hold, bus.rsp_data_o, legal ? 0 : 1, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    check({tag, "_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    check({tag, "_data"}, bus.rsp_data_o, 32'd0);
    check({tag, "_illegal"}, 32'(bus.rsp_illegal_o), 32'd0);
    check({tag, "_ctrl"}, 32'(bus.alu_ctrl_o), 32'(`ALU_ADD));
    check({tag, "_d1"}, bus.alu_data1_o, 32'd0);
    check({tag, "_d2"}, bus.alu_data2_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] ops [10];
    logic [2:0] f3s [10];
    logic [6:0] f7s [10];
    ops = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h33, 7'h13};
    f3s = '{3'd7,  3'd4,  3'd1,  3'd0,  3'd0,  3'd0,  3'd0,  3'd5,  3'd7,  3'd5};
    f7s = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h01, 7'h00, 7'h20, 7'h20, 7'h00};

    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    drive_garbage();
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;

    run_txn(7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 32'd99, 0);                 // ADD
    run_txn(7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'd1, 32'd4, 0);          // SRAI
    run_txn(7'h33, 3'd0, 7'h01, 32'd6, 32'd7, 32'd0, 0);                  // MUL
    run_txn(7'h33, 3'd7, 7'h20, 32'd1, 32'd2, 32'd3, 0);                  // illegal
    run_txn(7'h33, 3'd0, 7'h00, 32'd100, 32'd23, 32'd0, 5);               // ADD, stalled

    // Reset pulsed while a request is in flight.
    bus.opcode_i = 7'h33; bus.funct3_i = 3'd0; bus.funct7_i = 7'h01;
    bus.rs1_data_i = 32'd6; bus.rs2_data_i = 32'd7;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_d1 = 32'd0; exp_d2 = 32'd0; exp_ctrl = `ALU_ADD;
    check_reset_outputs("after_reset");
    run_txn(7'h33, 3'd4, 7'h00, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 0);  // XOR

    for (int n = 0; n < 60; n++) begin
      int k;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      k = int'($urandom_range(0, 10));
      if (k == 10) begin
        op = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
      end else begin
        op = ops[k]; f3 = f3s[k];
        f7 = (k == 6) ? 7'($urandom) : f7s[k];
      end
      run_txn(op, f3, f7, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
